// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC independent virtual-channel queues behind one shared write
// port and one shared read port. A round-robin arbiter selects a non-empty VC
// to feed a registered output stage using the valid_out/deq handshake.
// Per-VC full/almost_full flags give upstream routers credit backpressure.
//
// Build option: define VC_FIFO_OVERFLOW_EN to build the sticky overflow flag,
// which sets on any dropped write. Without it, overflow is tied low.
module vc_fifo #(
  parameter int FIFO_WIDTH    = 32,
  parameter int NUM_BIT_DEPTH = 3,
  parameter int NUM_VC        = 4,
  parameter int VC_BITS       = 2,
  parameter int AFULL_THRESH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [VC_BITS-1:0]    enq_vc,
  input  logic                  enq,
  output logic [NUM_VC-1:0]     full,
  output logic [NUM_VC-1:0]     almost_full,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic [VC_BITS-1:0]    out_vc,
  output logic                  valid_out,
  input  logic                  deq,
  output logic                  overflow
);

  localparam int DEPTH     = 1 << NUM_BIT_DEPTH;
  localparam int PTR_W     = NUM_BIT_DEPTH + 1;
  localparam int ADDR_W    = VC_BITS + NUM_BIT_DEPTH;
  localparam int MEM_WORDS = (1 << VC_BITS) * DEPTH;

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t                AFULL_CNT = ptr_t'(AFULL_THRESH);
  localparam logic [VC_BITS:0]    VC_LIMIT  = (VC_BITS + 1)'(NUM_VC);
  localparam logic [VC_BITS-1:0]  LAST_VC   = VC_BITS'(NUM_VC - 1);

  // Shared storage, addressed as {vc, slot}; each VC owns DEPTH slots.
  logic [FIFO_WIDTH-1:0] mem [MEM_WORDS];

  ptr_t head  [NUM_VC];
  ptr_t tail  [NUM_VC];
  ptr_t count [NUM_VC];

  logic [NUM_VC-1:0]        nonempty;
  logic [VC_BITS-1:0]       rr_ptr;
  logic [VC_BITS-1:0]       grant;
  logic [VC_BITS-1:0]       cand;
  logic                     grant_valid;
  logic                     load;
  logic                     pop;
  logic                     in_range;
  logic                     target_full;
  logic                     wr;
  logic [NUM_BIT_DEPTH-1:0] wr_addr;
  logic [NUM_BIT_DEPTH-1:0] rd_addr;
  logic [ADDR_W-1:0]        wr_index;
  logic [ADDR_W-1:0]        rd_index;

  // Per-VC occupancy and credit flags, derived from the registered pointers.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      count[v]       = tail[v] - head[v];
      nonempty[v]    = (tail[v] != head[v]);
      full[v]        = (tail[v][PTR_W-1] != head[v][PTR_W-1]) &&
                       (tail[v][NUM_BIT_DEPTH-1:0] == head[v][NUM_BIT_DEPTH-1:0]);
      almost_full[v] = (count[v] >= AFULL_CNT);
    end
  end

  // Write decode: accept only in-range VCs that are not full this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    target_full = 1'b0;
    wr_addr     = '0;
    in_range    = ({1'b0, enq_vc} < VC_LIMIT);
    for (int v = 0; v < NUM_VC; v++) begin
      if (enq_vc == VC_BITS'(v)) begin
        target_full = full[v];
        wr_addr     = tail[v][NUM_BIT_DEPTH-1:0];
      end
    end
    wr = enq && in_range && !target_full;
  end

  // Round-robin arbiter: scan from rr_ptr upward with wrap; the scan runs
  // backwards so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rd_addr     = '0;
    cand        = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      cand = VC_BITS'((int'(rr_ptr) + i) % NUM_VC);
      if (nonempty[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
        rd_addr     = head[cand][NUM_BIT_DEPTH-1:0];
      end
    end
  end

  assign load     = !valid_out || deq;
  assign pop      = load && grant_valid;
  assign wr_index = {enq_vc, wr_addr};
  assign rd_index = {grant, rd_addr};

  // Pointer and arbiter state: tails advance on accepted writes, the granted
  // head advances when its word moves into the output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head[v] <= '0;
        tail[v] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
        if (wr && (enq_vc == VC_BITS'(v))) tail[v] <= tail[v] + ptr_t'(1);
        if (pop && (grant == VC_BITS'(v))) head[v] <= head[v] + ptr_t'(1);
      end
      if (pop) rr_ptr <= (grant == LAST_VC) ? '0 : grant + VC_BITS'(1);
    end
  end

  // Registered output stage; data_out/out_vc hold when nothing is granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      out_vc    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        data_out  <= mem[rd_index];
        out_vc    <= grant;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

  // Queue storage write port.
  // NOTE: the storage array is not reset; head/tail alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (wr) mem[wr_index] <= data_in;
  end

`ifdef VC_FIFO_OVERFLOW_EN
  logic drop;
  assign drop = enq && !wr;

  // Sticky record of any dropped write (full VC or out-of-range VC).
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// Directed testbench for vc_fifo: reset state, write-to-output latency,
// fill/almost-full/full/drop, round-robin order, pointer wrap, simultaneous
// write and pop on a full VC, and asynchronous reset while busy.
`timescale 1ns/1ps
module tb_vc_fifo;

  localparam int FIFO_WIDTH    = 32;
  localparam int NUM_BIT_DEPTH = 3;
  localparam int NUM_VC        = 4;
  localparam int VC_BITS       = 2;
  localparam int AFULL_THRESH  = 6;

`ifdef VC_FIFO_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [VC_BITS-1:0]    enq_vc;
  logic                  enq;
  logic [NUM_VC-1:0]     full;
  logic [NUM_VC-1:0]     almost_full;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [VC_BITS-1:0]    out_vc;
  logic                  valid_out;
  logic                  deq;
  logic                  overflow;

  int errors = 0;
  int checks = 0;

  vc_fifo #(
    .FIFO_WIDTH    (FIFO_WIDTH),
    .NUM_BIT_DEPTH (NUM_BIT_DEPTH),
    .NUM_VC        (NUM_VC),
    .VC_BITS       (VC_BITS),
    .AFULL_THRESH  (AFULL_THRESH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .enq_vc      (enq_vc),
    .enq         (enq),
    .full        (full),
    .almost_full (almost_full),
    .data_out    (data_out),
    .out_vc      (out_vc),
    .valid_out   (valid_out),
    .deq         (deq),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  // One active edge, then return at the falling edge where outputs are sampled
  // and new inputs are driven.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    enq     = 1'b0;
    deq     = 1'b0;
    enq_vc  = '0;
    data_in = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [VC_BITS-1:0] vc, input logic [FIFO_WIDTH-1:0] d);
    enq_vc  = vc;
    data_in = d;
    enq     = 1'b1;
    tick();
    enq     = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if (out_vc !== 2'd0) begin errors++; $display("FAIL reset_out_vc: got %0d want 0", out_vc); end
    checks++; if (full !== 4'b0000) begin errors++; $display("FAIL reset_full: got %b want 0000", full); end
    checks++; if (almost_full !== 4'b0000) begin errors++; $display("FAIL reset_afull: got %b want 0000", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
  endtask

  task automatic test_latency();
    do_reset();
    write_word(2'd1, 32'hA5A5_A5A5);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lat_edge1_valid: got %0b want 0", valid_out); end
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL lat_edge2_valid: got %0b want 1", valid_out); end
    checks++; if (data_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL lat_edge2_data: got %h want a5a5a5a5", data_out); end
    checks++; if (out_vc !== 2'd1) begin errors++; $display("FAIL lat_edge2_vc: got %0d want 1", out_vc); end
    repeat (3) tick();
    checks++; if (valid_out !== 1'b1 || data_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL lat_hold: got valid=%0b data=%h want 1/a5a5a5a5", valid_out, data_out); end
    deq = 1'b1;
    tick();
    deq = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lat_after_deq: got %0b want 0", valid_out); end
  endtask

  task automatic test_fill();
    logic exp_af;
    logic exp_full;
    do_reset();
    // Park a VC1 word in the output register so VC0 storage is not popped.
    write_word(2'd1, 32'hA5A5_A5A5);
    for (int k = 1; k <= 8; k++) begin
      write_word(2'd0, 32'h100 + k - 1);
      exp_af   = (k >= 6);
      exp_full = (k == 8);
      checks++; if (almost_full[0] !== exp_af) begin errors++; $display("FAIL fill_afull_w%0d: got %0b want %0b", k, almost_full[0], exp_af); end
      checks++; if (full[0] !== exp_full) begin errors++; $display("FAIL fill_full_w%0d: got %0b want %0b", k, full[0], exp_full); end
    end
    write_word(2'd0, 32'h1FF);
    checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL fill_full_after_drop: got %0b want 1", full[0]); end
    checks++; if (overflow !== OVF_EXP) begin errors++; $display("FAIL fill_overflow: got %0b want %0b", overflow, OVF_EXP); end
    checks++; if (data_out !== 32'hA5A5_A5A5 || out_vc !== 2'd1) begin errors++; $display("FAIL fill_parked: got %h/vc%0d want a5a5a5a5/vc1", data_out, out_vc); end
    deq = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 32'h100 + k || out_vc !== 2'd0) begin errors++; $display("FAIL fill_drain_%0d: got v=%0b %h vc%0d want 1 %h vc0", k, valid_out, data_out, out_vc, 32'h100 + k); end
      if (k == 0) begin
        checks++; if (full[0] !== 1'b0) begin errors++; $display("FAIL fill_full_after_pop: got %0b want 0", full[0]); end
      end
    end
    tick();
    deq = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fill_empty_after_drain: got %0b want 0", valid_out); end
  endtask

  task automatic test_round_robin();
    logic [VC_BITS-1:0]    exp_vc;
    logic [FIFO_WIDTH-1:0] exp_data;
    do_reset();
    for (int v = 0; v < NUM_VC; v++)
      for (int i = 0; i < 2; i++)
        write_word(VC_BITS'(v), 32'(v * 16 + i));
    checks++; if (valid_out !== 1'b1 || out_vc !== 2'd0 || data_out !== 32'h0) begin errors++; $display("FAIL rr_first: got v=%0b vc%0d %h want 1 vc0 0", valid_out, out_vc, data_out); end
    deq = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      exp_vc   = VC_BITS'(k % 4);
      exp_data = 32'((k % 4) * 16 + k / 4);
      checks++; if (valid_out !== 1'b1 || out_vc !== exp_vc || data_out !== exp_data) begin errors++; $display("FAIL rr_word_%0d: got v=%0b vc%0d %h want 1 vc%0d %h", k, valid_out, out_vc, data_out, exp_vc, exp_data); end
    end
    tick();
    deq = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rr_empty: got %0b want 0", valid_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    deq    = 1'b1;
    enq_vc = 2'd2;
    for (int n = 0; n <= 20; n++) begin
      enq     = (n < 20);
      data_in = 32'(n);
      tick();
      if (n == 0) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL wrap_first_edge: got %0b want 0", valid_out); end
      end else begin
        checks++; if (valid_out !== 1'b1 || data_out !== 32'(n - 1) || out_vc !== 2'd2) begin errors++; $display("FAIL wrap_word_%0d: got v=%0b %h vc%0d want 1 %h vc2", n - 1, valid_out, data_out, out_vc, 32'(n - 1)); end
      end
      checks++; if (full[2] !== 1'b0) begin errors++; $display("FAIL wrap_full_%0d: got %0b want 0", n, full[2]); end
    end
    enq = 1'b0;
    tick();
    deq = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %0b want 0", valid_out); end
  endtask

  task automatic test_full_simul();
    do_reset();
    write_word(2'd0, 32'hD0);
    for (int i = 0; i < 8; i++) write_word(2'd3, 32'h30 + i);
    checks++; if (full[3] !== 1'b1 || almost_full[3] !== 1'b1) begin errors++; $display("FAIL simul_pre_full: got full=%0b af=%0b want 1/1", full[3], almost_full[3]); end
    checks++; if (data_out !== 32'hD0 || out_vc !== 2'd0) begin errors++; $display("FAIL simul_parked: got %h vc%0d want d0 vc0", data_out, out_vc); end
    enq_vc  = 2'd3;
    data_in = 32'hBAD;
    enq     = 1'b1;
    deq     = 1'b1;
    #1;
    checks++; if (full[3] !== 1'b1) begin errors++; $display("FAIL simul_full_in_cycle: got %0b want 1", full[3]); end
    tick();
    enq = 1'b0;
    checks++; if (data_out !== 32'h30 || out_vc !== 2'd3) begin errors++; $display("FAIL simul_pop: got %h vc%0d want 30 vc3", data_out, out_vc); end
    checks++; if (overflow !== OVF_EXP) begin errors++; $display("FAIL simul_overflow: got %0b want %0b", overflow, OVF_EXP); end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 32'h30 + i) begin errors++; $display("FAIL simul_drain_%0d: got v=%0b %h want 1 %h", i, valid_out, data_out, 32'h30 + i); end
    end
    tick();
    deq = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL simul_write_dropped: got v=%0b data=%h want v=0", valid_out, data_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_word(2'd1, 32'h11);
    for (int i = 0; i < 8; i++) write_word(2'd2, 32'h20 + i);
    write_word(2'd2, 32'h2F);
    checks++; if (valid_out !== 1'b1 || full[2] !== 1'b1 || overflow !== OVF_EXP) begin errors++; $display("FAIL areset_pre: got v=%0b full2=%0b ovf=%0b want 1/1/%0b", valid_out, full[2], overflow, OVF_EXP); end
    #2 reset = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL areset_valid: got %0b want 0", valid_out); end
    checks++; if (full !== 4'b0000 || almost_full !== 4'b0000) begin errors++; $display("FAIL areset_flags: got full=%b af=%b want 0000/0000", full, almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_overflow: got %0b want 0", overflow); end
    checks++; if (data_out !== 32'h0 || out_vc !== 2'd0) begin errors++; $display("FAIL areset_data: got %h vc%0d want 0 vc0", data_out, out_vc); end
    #1 reset = 1'b0;
    repeat (4) tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL areset_idle: got %0b want 0", valid_out); end
    write_word(2'd3, 32'h77);
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== 32'h77 || out_vc !== 2'd3) begin errors++; $display("FAIL areset_new_word: got v=%0b %h vc%0d want 1 77 vc3", valid_out, data_out, out_vc); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_round_robin();
    test_wrap();
    test_full_simul();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
